// File: rtl/pkt_dequeue_ctrl_pkg.sv
// Shared definitions for the packet dequeue controller: FSM encoding and default widths.
package pkt_dequeue_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 12;
  localparam int unsigned DEF_DATA_WIDTH  = 256;
  localparam int unsigned DEF_TUSER_WIDTH = 128;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  function automatic int unsigned keep_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/pkt_dequeue_ctrl_if.sv
// AXI-Stream egress bundle of the packet dequeue controller.
interface pkt_dequeue_ctrl_if
  import pkt_dequeue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned TUSER_WIDTH = DEF_TUSER_WIDTH
) ();

  localparam int unsigned KEEP_WIDTH = keep_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0]  tdata;
  logic [KEEP_WIDTH-1:0]  tkeep;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);

endinterface

// File: rtl/pkt_dequeue_ctrl_axis_skid_2.sv
// Two-entry output FIFO with registered outputs; head register drives the stream directly.
module axis_skid_2
  import pkt_dequeue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_spare;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_count != 2'd2);
  assign w_pop   = (r_count != 2'd0) && i_ready;
  assign o_data  = r_head;
  assign o_count = r_count;

  // Head always holds the oldest entry; spare only used when both slots are occupied.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_spare <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head  <= i_data;
          else                 r_spare <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_spare;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head  <= r_spare;
            r_spare <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pkt_dequeue_ctrl.sv
// Packet dequeue controller: turns scheduler descriptors into buffer reads and an egress stream.
module pkt_dequeue_ctrl
  import pkt_dequeue_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned TUSER_WIDTH = DEF_TUSER_WIDTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          s_desc_valid,
  output logic                          s_desc_ready,
  input  logic [ADDR_WIDTH-1:0]         s_desc_sop_addr,
  output logic                          buf_rd_first_word_en,
  output logic [ADDR_WIDTH-1:0]         buf_rd_pkt_sop_addr,
  output logic                          buf_rd_en,
  input  logic                          buf_is_empty,
  input  logic [DATA_WIDTH-1:0]         buf_tdata,
  input  logic [keep_width(DATA_WIDTH)-1:0] buf_tkeep,
  input  logic                          buf_tlast,
  input  logic [TUSER_WIDTH-1:0]        buf_tuser,
  pkt_dequeue_ctrl_if.master            m_axis,
  output logic                          pkt_done,
  output logic                          err_underflow
);

  localparam int unsigned KEEP_WIDTH = keep_width(DATA_WIDTH);
  localparam int unsigned PAYLOAD_W  = TUSER_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_err_underflow;
  logic                   w_first;
  logic                   w_rd_en;
  logic                   w_push;
  logic                   w_pkt_done;
  logic                   w_uflow_set;
  logic [1:0]             w_skid_count;
  logic [PAYLOAD_W-1:0]   w_buf_word;
  logic [PAYLOAD_W-1:0]   w_skid_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state         <= ST_IDLE;
      r_err_underflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_uflow_set) r_err_underflow <= 1'b1;
    end
  end

  // Capture decision uses only the registered skid count, keeping tready off the read path.
  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_rd_en     = 1'b0;
    w_push      = 1'b0;
    w_pkt_done  = 1'b0;
    w_uflow_set = 1'b0;
    if (rstn) begin
      case (r_state)
        ST_IDLE: begin
          if (s_desc_valid) begin
            if (buf_is_empty) begin
              w_uflow_set = 1'b1;
            end else begin
              w_first     = 1'b1;
              w_state_nxt = ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (w_skid_count != 2'd2) begin
            w_push = 1'b1;
            if (buf_tlast) begin
              w_pkt_done  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_rd_en = 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_buf_word = {buf_tuser, buf_tlast, buf_tkeep, buf_tdata};

  axis_skid_2 #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  (w_buf_word),
    .i_ready (m_axis.tready),
    .o_data  (w_skid_data),
    .o_count (w_skid_count)
  );

  assign s_desc_ready         = (r_state == ST_IDLE);
  assign buf_rd_first_word_en = w_first;
  assign buf_rd_pkt_sop_addr  = s_desc_sop_addr;
  assign buf_rd_en            = w_rd_en;
  assign pkt_done             = w_pkt_done;
  assign err_underflow        = r_err_underflow;

  assign m_axis.tvalid = (w_skid_count != 2'd0);
  assign m_axis.tdata  = w_skid_data[DATA_WIDTH-1:0];
  assign m_axis.tkeep  = w_skid_data[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis.tlast  = w_skid_data[DATA_WIDTH + KEEP_WIDTH];
  assign m_axis.tuser  = w_skid_data[PAYLOAD_W-1 -: TUSER_WIDTH];

endmodule

// File: tb/tb_pkt_dequeue_ctrl.sv
// Scoreboard bench for pkt_dequeue_ctrl: cycle tables for control timing, queue for egress data.
module tb_pkt_dequeue_ctrl;
  import pkt_dequeue_ctrl_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 256;
  localparam int unsigned KW = 32;
  localparam int unsigned UW = 128;

  typedef struct packed {
    logic [UW-1:0] user;
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s_desc_valid;
  logic          s_desc_ready;
  logic [AW-1:0] s_desc_sop_addr;
  logic          buf_rd_first_word_en;
  logic [AW-1:0] buf_rd_pkt_sop_addr;
  logic          buf_rd_en;
  logic          buf_is_empty;
  logic [DW-1:0] buf_tdata;
  logic [KW-1:0] buf_tkeep;
  logic          buf_tlast;
  logic [UW-1:0] buf_tuser;
  logic          pkt_done;
  logic          err_underflow;

  pkt_dequeue_ctrl_if m_axis ();

  always #5 clk = ~clk;

  pkt_dequeue_ctrl dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .s_desc_valid         (s_desc_valid),
    .s_desc_ready         (s_desc_ready),
    .s_desc_sop_addr      (s_desc_sop_addr),
    .buf_rd_first_word_en (buf_rd_first_word_en),
    .buf_rd_pkt_sop_addr  (buf_rd_pkt_sop_addr),
    .buf_rd_en            (buf_rd_en),
    .buf_is_empty         (buf_is_empty),
    .buf_tdata            (buf_tdata),
    .buf_tkeep            (buf_tkeep),
    .buf_tlast            (buf_tlast),
    .buf_tuser            (buf_tuser),
    .m_axis               (m_axis),
    .pkt_done             (pkt_done),
    .err_underflow        (err_underflow)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Packets: 0x010 (4 words), 0x020 (1), 0x100 (3), 0x200 (6)
  function automatic logic is_last(input logic [AW-1:0] a);
    return (a == 12'h013) || (a == 12'h020) || (a == 12'h102) || (a == 12'h205);
  endfunction

  function automatic beat_t mk_beat(input logic [AW-1:0] a);
    beat_t b;
    b.data = {8{20'hDA7A0, a}};
    b.keep = {20'hFFFFF, a};
    b.last = is_last(a);
    b.user = {8{4'hC, a}};
    return b;
  endfunction

  // Packet buffer model: word appears the cycle after a strobe and holds until the next one.
  logic [AW-1:0] b_ptr = '0;
  always @(posedge clk) begin
    if (buf_rd_first_word_en)  b_ptr <= buf_rd_pkt_sop_addr;
    else if (buf_rd_en)        b_ptr <= b_ptr + AW'(1);
  end

  always_comb begin
    beat_t w;
    w         = mk_beat(b_ptr);
    buf_tdata = w.data;
    buf_tkeep = w.keep;
    buf_tlast = w.last;
    buf_tuser = w.user;
  end

  beat_t exp_q[$];

  task automatic push_pkt(input logic [AW-1:0] sop);
    logic [AW-1:0] a;
    a = sop;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(mk_beat(a));
      if (is_last(a)) break;
      a = a + AW'(1);
    end
  endtask

  task automatic chk(input string name, input int cyc, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc%0d got 0x%0h exp 0x%0h", name, cyc, got, exp);
  endtask

  // Egress monitor: every valid beat must equal the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    beat_t got;
    if (rstn === 1'b1 && m_axis.tvalid === 1'b1) begin
      got = {m_axis.tuser, m_axis.tlast, m_axis.tkeep, m_axis.tdata};
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL beat_unexpected got data 0x%0h last %0b exp none", got.data[31:0], got.last);
      end else if (got !== exp_q[0]) begin
        $display("FAIL beat got 0x%0h exp 0x%0h", got, exp_q[0]);
      end else begin
        n_pass++;
      end
      if (m_axis.tready === 1'b1 && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // Per-cycle stimulus and expected {err, ready, first, rd_en, pkt_done, tvalid}
  logic [5:0]    exp_tab [16];
  logic          dv_tab  [16];
  logic [AW-1:0] sop_tab [16];
  logic          tr_tab  [16];
  logic          rst_tab [16];

  task automatic clr_tab();
    for (int i = 0; i < 16; i++) begin
      exp_tab[i] = 6'b0;
      dv_tab[i]  = 1'b0;
      sop_tab[i] = '0;
      tr_tab[i]  = 1'b1;
      rst_tab[i] = 1'b1;
    end
  endtask

  task automatic row(input int i, input logic dv, input logic [AW-1:0] sop, input logic [5:0] e);
    dv_tab[i]  = dv;
    sop_tab[i] = sop;
    exp_tab[i] = e;
  endtask

  task automatic run_vec(input string name, input int n);
    logic [5:0] got;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i > 0 && !rst_tab[i-1]) exp_q.delete();
      rstn            = rst_tab[i];
      s_desc_valid    = dv_tab[i];
      s_desc_sop_addr = sop_tab[i];
      m_axis.tready   = tr_tab[i];
      if (dv_tab[i] && exp_tab[i][4] && !buf_is_empty && rst_tab[i]) push_pkt(sop_tab[i]);
      @(negedge clk);
      got = {err_underflow, s_desc_ready, buf_rd_first_word_en, buf_rd_en, pkt_done, m_axis.tvalid};
      chk(name, i, 64'(got), 64'(exp_tab[i]));
    end
  endtask

  task automatic fill_t1(input logic e);
    clr_tab();
    row(0, 1'b1, 12'h010, {e, 5'b11000});
    row(1, 1'b0, 12'h000, {e, 5'b00100});
    row(2, 1'b0, 12'h000, {e, 5'b00101});
    row(3, 1'b0, 12'h000, {e, 5'b00101});
    row(4, 1'b0, 12'h000, {e, 5'b00011});
    row(5, 1'b0, 12'h000, {e, 5'b10001});
    row(6, 1'b0, 12'h000, {e, 5'b10000});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn            = 1'b0;
    s_desc_valid    = 1'b0;
    s_desc_sop_addr = '0;
    buf_is_empty    = 1'b0;
    m_axis.tready   = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 0, 64'(m_axis.tvalid), 64'd0);
    chk("rst_tdata", 0, 64'(m_axis.tdata[63:0]), 64'd0);
    chk("rst_tlast_keep", 0, 64'({m_axis.tlast, m_axis.tkeep}), 64'd0);
    chk("rst_err", 0, 64'(err_underflow), 64'd0);
    chk("rst_ready", 0, 64'(s_desc_ready), 64'd1);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 0, 64'(s_desc_ready), 64'd1);

    // 4-word packet, free-flowing egress
    fill_t1(1'b0);
    run_vec("pkt4", 7);

    // Same packet with egress stalled for five cycles from c2
    clr_tab();
    row(0, 1'b1, 12'h010, 6'b011000);
    row(1, 1'b0, 12'h000, 6'b000100);
    row(2, 1'b0, 12'h000, 6'b000101);
    for (int i = 3; i <= 7; i++) row(i, 1'b0, 12'h000, 6'b000001);
    row(8, 1'b0, 12'h000, 6'b000101);
    row(9, 1'b0, 12'h000, 6'b000011);
    row(10, 1'b0, 12'h000, 6'b010001);
    row(11, 1'b0, 12'h000, 6'b010000);
    for (int i = 2; i <= 6; i++) tr_tab[i] = 1'b0;
    run_vec("stall", 12);

    // Back-to-back descriptors: 1-word then 3-word
    clr_tab();
    row(0, 1'b1, 12'h020, 6'b011000);
    row(1, 1'b1, 12'h100, 6'b000010);
    row(2, 1'b1, 12'h100, 6'b011001);
    row(3, 1'b0, 12'h000, 6'b000100);
    row(4, 1'b0, 12'h000, 6'b000101);
    row(5, 1'b0, 12'h000, 6'b000011);
    row(6, 1'b0, 12'h000, 6'b010001);
    row(7, 1'b0, 12'h000, 6'b010000);
    run_vec("b2b", 8);

    // Descriptor against an empty buffer
    buf_is_empty = 1'b1;
    clr_tab();
    row(0, 1'b1, 12'h030, 6'b010000);
    row(1, 1'b0, 12'h000, 6'b110000);
    row(2, 1'b0, 12'h000, 6'b110000);
    run_vec("uflow", 3);
    buf_is_empty = 1'b0;

    // Normal traffic after underflow: error stays set
    fill_t1(1'b1);
    run_vec("sticky", 7);

    // Reset while the 6-word packet is in flight
    clr_tab();
    row(0, 1'b1, 12'h200, 6'b111000);
    row(1, 1'b0, 12'h000, 6'b100100);
    row(2, 1'b0, 12'h000, 6'b100001);
    row(3, 1'b0, 12'h000, 6'b010000);
    row(4, 1'b0, 12'h000, 6'b010000);
    row(5, 1'b0, 12'h000, 6'b010000);
    rst_tab[2] = 1'b0;
    run_vec("midrst", 6);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 0, 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pkt_dequeue_ctrl.md
PKT_DEQUEUE_CTRL -- requirements
Module: pkt_dequeue_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, buffer word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 256, stream data width; keep width DATA_WIDTH/8.
REQ-003 SHALL have parameter TUSER_WIDTH, default 128, metadata width.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_desc_valid  in  1  descriptor (packet SOP address) offered by the scheduler.
REQ-007 SHALL have port s_desc_ready  out  1  descriptor accepted when high with s_desc_valid.
REQ-008 SHALL have port s_desc_sop_addr  in  ADDR_WIDTH  buffer address of the packet's first word.
REQ-009 SHALL have port buf_rd_first_word_en  out  1  first-word read strobe to the packet buffer.
REQ-010 SHALL have port buf_rd_pkt_sop_addr  out  ADDR_WIDTH  SOP address qualified by buf_rd_first_word_en.
REQ-011 SHALL have port buf_rd_en  out  1  advance-to-next-word read strobe.
REQ-012 SHALL have port buf_is_empty  in  1  buffer holds zero words.
REQ-013 SHALL have port buf_tdata  in  DATA_WIDTH  buffer read data, valid 1 cycle after a read strobe, stable until the next strobe.
REQ-014 SHALL have port buf_tkeep  in  DATA_WIDTH/8  buffer read keep.
REQ-015 SHALL have port buf_tlast  in  1  buffer read end-of-packet.
REQ-016 SHALL have port buf_tuser  in  TUSER_WIDTH  buffer read metadata.
REQ-017 SHALL have port m_axis_tdata  out  DATA_WIDTH  egress data.
REQ-018 SHALL have port m_axis_tkeep  out  DATA_WIDTH/8  egress keep.
REQ-019 SHALL have port m_axis_tlast  out  1  egress end-of-packet.
REQ-020 SHALL have port m_axis_tuser  out  TUSER_WIDTH  egress metadata.
REQ-021 SHALL have port m_axis_tvalid  out  1  egress valid.
REQ-022 SHALL have port m_axis_tready  in  1  egress ready.
REQ-023 SHALL have port pkt_done  out  1  one-cycle pulse when a packet's last word is captured from the buffer.
REQ-024 SHALL have port err_underflow  out  1  sticky: descriptor accepted while buf_is_empty.

Function
REQ-025 SHALL implement FSM IDLE/STREAM; s_desc_ready = (state==IDLE).
REQ-026 IDLE, s_desc_valid & ~buf_is_empty: assert buf_rd_first_word_en, drive buf_rd_pkt_sop_addr = s_desc_sop_addr combinationally, same cycle; next state STREAM.
REQ-027 IDLE, s_desc_valid & buf_is_empty: consume descriptor, issue no read, set err_underflow, stay IDLE.
REQ-028 STREAM: buffer word valid on buf_*; when skid count < 2 (registered count only, no tready path), capture word into skid.
REQ-029 STREAM capture with buf_tlast=0: assert buf_rd_en same cycle, stay STREAM; with buf_tlast=1: no buf_rd_en, pulse pkt_done, next IDLE.
REQ-030 STREAM with skid full: no capture, no read strobe, buffer output held.
REQ-031 buf_rd_first_word_en and buf_rd_en SHALL never be high in the same cycle; each at most one pulse per captured word.
REQ-032 Skid: 2-entry FIFO, registered outputs; m_axis_tvalid = count!=0; pop on tvalid&tready; simultaneous push/pop keeps count.
REQ-033 Throughput: 1 word/cycle sustained within a packet with tready=1; exactly one idle cycle on the buffer read side between packets.
REQ-034 m_axis_* SHALL hold stable while tvalid=1 and tready=0.

Reset
REQ-035 rstn=0 at clk edge: state IDLE, skid empty, m_axis_tvalid=0, m_axis_* data 0, pkt_done=0, err_underflow=0, read strobes 0.
REQ-036 Reset mid-packet SHALL discard the in-flight packet and skid contents; no partial word emitted after reset.

Structure
REQ-037 Shared package SHALL hold FSM state encoding and default width constants (ADDR 12, DATA 256, TUSER 128).
REQ-038 Sub-module axis_skid_2 SHALL implement the 2-entry output FIFO.

Verification
REQ-039 Desc sop=0x010, 4-word packet, tready=1 -> first_word_en@c0, rd_en@c1..c3, tvalid c2..c5, tlast on word 4, pkt_done@c4.
REQ-040 Same packet, tready=0 for 5 cycles from c2 -> two words captured, rd_en stalls, data stable, no loss/duplication after release.
REQ-041 Two back-to-back descs (1-word sop=0x020, 3-word sop=0x100) -> 4 words in order, single bubble between, s_desc_ready low during STREAM.
REQ-042 Desc with buf_is_empty=1 -> no read strobes, err_underflow=1 and sticky until reset.
REQ-043 rstn low during word 2 of 6-word packet -> tvalid=0 next cycle, state IDLE, s_desc_ready=1 after release.
